lsu: RTL and testbench
======================

# lsu

Load/store unit between the core's memory stage and the 128×32 word RAM. Accepts byte, halfword and word loads/stores on a byte address and returns sign- or zero-extended load data. The RAM has no byte enables, so sub-word stores run as read-modify-write. The RAM's registered one-cycle read latency, and its rule of no read while `wren` is high, set the FSM timing.

## Interface
- `ADDR_W`, 7, RAM word-address width; the byte address is `ADDR_W+2` bits.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; accept = `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  zero-extend loads.
- `req_addr`  in  ADDR_W+2  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle pulse; no backpressure.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal size (only with the check macro).
- `mem_wren`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_W  word address; equals the latched `req_addr[ADDR_W+1:2]`.
- `mem_wdata`  out  32  merged write word; 0 when `mem_wren` = 0.
- `mem_rdata`  in  32  RAM registered read data.

## Operation
- States: IDLE, RD, DATA, WR.
- IDLE, on accept: latch addr, size, we, unsigned, wdata.
  - Error (check enabled) -> register `rsp_valid`=1, `rsp_err`=1; stay IDLE.
  - Word store -> WR with merged word = `req_wdata`.
  - Load or sub-word store -> RD.
- RD: `mem_wren`=0; the RAM captures the read at the end of the cycle. -> DATA.
- DATA: `mem_rdata` is valid.
  - Load: register the extracted result, `rsp_valid`=1. -> IDLE.
  - Sub-word store: register the merged word. -> WR.
- WR: `mem_wren`=1, `mem_wdata`=merged word; register `rsp_valid`=1. -> IDLE.
- Lane select, little-endian, offset `addr[1:0]`:
  - byte: lane `addr[1:0]`.
  - half: lanes `{addr[1],0}` and `{addr[1],1}`.
  - word: all lanes.
- Load extension: sign-extend from bit 7/15 unless `req_unsigned`.
- Store merge: replace only the selected lanes with `req_wdata[7:0]` / `[15:0]`; keep the other bytes from `mem_rdata`.
- Reset: async to IDLE. `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, latched regs 0. `mem_wren` drops combinationally.

## Timing
- Accept edge = E0.
- Load: RD in E0–E1, DATA in E1–E2; `rsp_valid` high E2–E3.
- Word store: `mem_wren` in E0–E1; `rsp_valid` E1–E2.
- Sub-word store: RD, DATA, WR in E2–E3 with `mem_wren`; `rsp_valid` E3–E4.
- Error: `rsp_valid`+`rsp_err` in E0–E1, no RAM access.
- The response cycle is IDLE, so a new request can be accepted in the same cycle as `rsp_valid` (back-to-back).
- Reset mid-WR before the edge: write is lost, RAM unchanged, no response.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11 -> error response.
- Not defined:
  - `rsp_err` tied to 0.
  - Offending low address bits are forced to 0.
  - Size 11 is treated as a word.

## Structure
- `lsu_pkg`: size encodings `SIZE_B`/`SIZE_H`/`SIZE_W`, state enum, lane-offset helpers.
- Sub-module `lsu_lane`: combinational load extract/extend and store merge; instantiated once.
- FSM and registers live in `lsu`.

## Test plan
All scenarios preload RAM word 7 = 0x8899AABB.
- Signed byte load at 0x1D -> `rsp_rdata` 0xFFFFFFAA, `rsp_valid` 2 cycles after accept.
- Unsigned half load at 0x1E -> 0x00008899. Signed half load at 0x1E -> 0xFFFF8899.
- Byte store at 0x1C, wdata 0x1234565A -> `mem_wren` in 3rd cycle with `mem_wdata` 0x8899AA5A. A following word load at 0x1C returns 0x8899AA5A.
- Word store 0xDEADBEEF at 0x00, then `req_valid` held with a word load at 0x00 -> second accept coincides with the first `rsp_valid`. Load returns 0xDEADBEEF.
- Half load at 0x1D:
  - With `LSU_ALIGN_CHECK_EN`: `rsp_err`=1 one cycle after accept, `mem_wren` never set.
  - Without: result 0xFFFFAABB, as if at 0x1C.
- Assert `rst` mid-cycle during WR of a byte store -> `mem_wren` falls immediately, `rsp_valid` stays 0, word 7 still 0x8899AABB.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   SIZE_B/SIZE_H/SIZE_W : request size encodings (2'b11 is illegal)
//   state_t              : FSM states of lsu
//   misaligned()         : true when a size/offset pair is not naturally aligned
//   norm_size/norm_off() : legalise size and offset when alignment checking is off
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_DATA = 2'd2,
    S_WR   = 2'd3
  } state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return off[0];
      SIZE_W:  return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  // Illegal size 11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_W : size;
  endfunction

  // Drop offset bits that would make the access misaligned.
  function automatic logic [1:0] norm_off(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_B:  return off;
      SIZE_H:  return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational lane logic for the load/store unit.
//   size, off  : normalised access size and byte offset within the word
//   uns        : zero-extend loads instead of sign-extending
//   rdata      : word read from the RAM
//   wdata      : right-aligned store data
//   load_data  : extracted and extended load result
//   store_word : rdata with the selected lanes replaced by wdata
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rdata[{off, 3'b000} +: 8];
    half_sel   = rdata[{off[1], 4'b0000} +: 16];
    load_data  = rdata;
    store_word = rdata;
    case (size)
      SIZE_B: begin
        load_data = {{24{byte_sel[7] & ~uns}}, byte_sel};
        store_word[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_H: begin
        load_data = {{16{half_sel[15] & ~uns}}, half_sel};
        store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_data  = rdata;
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between the memory stage and a 128x32 word RAM with
// one-cycle registered reads and no byte enables (sub-word stores are RMW).
// Optional feature macro: LSU_ALIGN_CHECK_EN (misaligned/illegal-size requests
// get an error response; otherwise offending offset bits are dropped).
// Ports:
//   clk, rst                  : clock, async active-high reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata : request fields (byte address)
//   rsp_valid/rsp_rdata/rsp_err     : one-cycle response pulse
//   mem_wren/mem_addr/mem_wdata/mem_rdata : RAM port
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state_q, state_d;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              we_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;

  logic              accept;
  logic              req_bad;
  logic [1:0]        req_size_n;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

`ifdef LSU_ALIGN_CHECK_EN
  assign req_bad = misaligned(req_size, req_addr[1:0]);
`else
  assign req_bad = 1'b0;
`endif

  assign req_size_n = norm_size(req_size);
  assign accept     = req_valid && req_ready;
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_wdata  = mem_wren ? merge_q : 32'h0;

  lsu_lane u_lane (
    .size       (size_q),
    .off        (addr_q[1:0]),
    .uns        (uns_q),
    .rdata      (mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_wren  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_bad) begin
          if (req_we && req_size_n == SIZE_W) state_d = S_WR;
          else                                state_d = S_RD;
        end
      end
      S_RD:   state_d = S_DATA;
      S_DATA: state_d = we_q ? S_WR : S_IDLE;
      S_WR: begin
        mem_wren = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      merge_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (accept) begin
        addr_q  <= {req_addr[ADDR_W+1:2], norm_off(req_size_n, req_addr[1:0])};
        size_q  <= req_size_n;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        // Word stores skip the read, so the merged word is the store data itself.
        merge_q <= req_wdata;
        if (req_bad) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end
      end
      if (state_q == S_DATA) begin
        if (we_q) begin
          merge_q <= store_word;
        end else begin
          rsp_valid <= 1'b1;
          rsp_rdata <= load_data;
        end
      end
      if (state_q == S_WR) rsp_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wren;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu #(.ADDR_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_wren     (mem_wren),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // RAM model: registered read, no read while writing; bench preload port.
  logic [31:0] ram [128];
  logic        pre_we;
  logic [6:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end else begin
      mem_rdata <= ram[mem_addr];
      if (pre_we) ram[pre_addr] <= pre_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload7(input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 7'd7; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Drives one request for a single cycle; returns just after the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [8:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [1:0] size, input logic uns,
                            input logic [8:0] addr, input logic [31:0] exp);
    issue(1'b0, size, uns, addr, 32'h0);
    @(negedge clk);
    check({tag, "_c1_valid"}, rsp_valid, 0);
    check({tag, "_c1_ready"}, req_ready, 0);
    @(negedge clk);
    check({tag, "_c2_valid"}, rsp_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_rdata"}, rsp_rdata, exp);
    check({tag, "_err"}, rsp_err, 0);
    @(negedge clk);
    check({tag, "_pulse"}, rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    preload7(32'h8899AABB);

    // Loads from word 7
    load_check("lb_1d", 2'b00, 1'b0, 9'h1D, 32'hFFFFFFAA);
    load_check("lhu_1e", 2'b01, 1'b1, 9'h1E, 32'h00008899);
    load_check("lh_1e", 2'b01, 1'b0, 9'h1E, 32'hFFFF8899);
    load_check("lbu_1f", 2'b00, 1'b1, 9'h1F, 32'h00000088);

    // Byte store: read-modify-write
    issue(1'b1, 2'b00, 1'b0, 9'h1C, 32'h1234565A);
    @(negedge clk);
    check("sb_c1_wren", mem_wren, 0);
    @(negedge clk);
    check("sb_c2_wren", mem_wren, 0);
    @(negedge clk);
    check("sb_wren", mem_wren, 1);
    check("sb_wdata", mem_wdata, 32'h8899AA5A);
    check("sb_addr", mem_addr, 7);
    check("sb_c3_valid", rsp_valid, 0);
    @(negedge clk);
    check("sb_valid", rsp_valid, 1);
    check("sb_rdata", rsp_rdata, 0);
    check("sb_wren_off", mem_wren, 0);
    check("sb_wdata_off", mem_wdata, 0);
    load_check("lw_1c", 2'b10, 1'b0, 9'h1C, 32'h8899AA5A);

    // Halfword store into upper lanes
    issue(1'b1, 2'b01, 1'b0, 9'h1E, 32'hFFFF1357);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("sh_wdata", mem_wdata, 32'h1357AA5A);
    @(negedge clk);
    check("sh_valid", rsp_valid, 1);

    // Word store, then back-to-back word load held on req_valid
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 9'h000;
    req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = 32'h0;
    @(negedge clk);
    check("sw_wren", mem_wren, 1);
    check("sw_wdata", mem_wdata, 32'hDEADBEEF);
    check("sw_addr", mem_addr, 0);
    check("sw_ready", req_ready, 0);
    @(negedge clk);
    check("sw_valid", rsp_valid, 1);
    check("b2b_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_c1_valid", rsp_valid, 0);
    check("b2b_c1_wren", mem_wren, 0);
    @(negedge clk);
    check("b2b_c2_valid", rsp_valid, 0);
    @(negedge clk);
    check("b2b_valid", rsp_valid, 1);
    check("b2b_rdata", rsp_rdata, 32'hDEADBEEF);

    // Misaligned half and illegal size
    preload7(32'h8899AABB);
`ifdef LSU_ALIGN_CHECK_EN
    issue(1'b0, 2'b01, 1'b0, 9'h1D, 32'h0);
    @(negedge clk);
    check("mis_valid", rsp_valid, 1);
    check("mis_err", rsp_err, 1);
    check("mis_rdata", rsp_rdata, 0);
    check("mis_wren", mem_wren, 0);
    check("mis_ready", req_ready, 1);
    @(negedge clk);
    check("mis_pulse", rsp_valid, 0);
    check("mis_wren2", mem_wren, 0);
    issue(1'b1, 2'b11, 1'b0, 9'h1C, 32'h0);
    @(negedge clk);
    check("ill_err", rsp_err, 1);
    check("ill_wren", mem_wren, 0);
    @(negedge clk);
    check("ill_wren2", mem_wren, 0);
`else
    load_check("mis_lh_1d", 2'b01, 1'b0, 9'h1D, 32'hFFFFAABB);
    load_check("ill_sz_1e", 2'b11, 1'b0, 9'h1E, 32'h8899AABB);
`endif

    // Reset during WR of a byte store
    issue(1'b1, 2'b00, 1'b0, 9'h1C, 32'h000000FF);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("rwr_wren", mem_wren, 1);
    #1 rst = 1'b1;
    #1 check("rwr_wren_drop", mem_wren, 0);
    @(posedge clk);
    #1 check("rwr_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    check("rwr_ram7", ram[7], 32'h8899AABB);
    @(negedge clk);
    check("rwr_valid2", rsp_valid, 0);
    check("rwr_ready", req_ready, 1);
    load_check("rwr_lw", 2'b10, 1'b0, 9'h1C, 32'h8899AABB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
